// File: rtl/alu_packet_parser.sv
// Command-frame responder between uart_rx and uart_tx: parses a 4-byte header, then echoes
// or drops the payload. Optional inter-byte timeout is enabled with PKT_PARSER_TIMEOUT_EN.
module alu_packet_parser #(
  parameter logic [7:0]  EchoOpcode    = 8'hEC,
  parameter int unsigned TimeoutCycles = 1000000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  s_axis_tdata_i,
  input  logic        s_axis_tvalid_i,
  output logic        s_axis_tready_o,
  output logic [7:0]  m_axis_tdata_o,
  output logic        m_axis_tvalid_o,
  input  logic        m_axis_tready_i,
  output logic [7:0]  opcode_o,
  output logic [15:0] length_o,
  output logic        busy_o,
  output logic        pkt_done_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    StIdle,
    StRsvd,
    StLenLo,
    StLenHi,
    StFwd,
    StDrop
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [15:0] length_q, length_d;
  logic [15:0] remaining_q, remaining_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        s_ready;
  logic        accept;
  logic        emit;
  logic [15:0] full_len;
  logic        tmo_hit;

  // Only FWD needs the one-entry output register; every other state can always take a byte.
  always_comb begin
    s_ready  = (state_q == StFwd) ? (!out_valid_q || m_axis_tready_i) : 1'b1;
    accept   = s_axis_tvalid_i && s_ready;
    emit     = out_valid_q && m_axis_tready_i;
    full_len = {s_axis_tdata_i, length_q[7:0]};
  end

`ifdef PKT_PARSER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);

  logic [TmoW-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_hit = (state_q != StIdle) && !accept && (tmo_q == TmoW'(TimeoutCycles - 1));
    tmo_d   = tmo_q;
    if (accept || tmo_hit) begin
      tmo_d = '0;
    end else if (state_q != StIdle) begin
      tmo_d = tmo_q + TmoW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    length_d    = length_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !emit;
    done_d      = 1'b0;
    err_d       = 1'b0;

    if (accept) begin
      unique case (state_q)
        StIdle: begin
          opcode_d = s_axis_tdata_i;
          err_d    = (s_axis_tdata_i != EchoOpcode);
          state_d  = StRsvd;
        end
        StRsvd: begin
          state_d = StLenLo;
        end
        StLenLo: begin
          length_d[7:0] = s_axis_tdata_i;
          state_d       = StLenHi;
        end
        StLenHi: begin
          length_d[15:8] = s_axis_tdata_i;
          remaining_d    = full_len - 16'd4;
          // Lengths of 4 or less carry no payload; the frame ends on this byte.
          if (full_len <= 16'd4) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else if (opcode_q == EchoOpcode) begin
            state_d = StFwd;
          end else begin
            state_d = StDrop;
          end
        end
        StFwd: begin
          out_data_d  = s_axis_tdata_i;
          out_valid_d = 1'b1;
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
        StDrop: begin
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    if (tmo_hit) begin
      state_d     = StIdle;
      err_d       = 1'b1;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      opcode_q    <= '0;
      length_q    <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      length_q    <= length_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign s_axis_tready_o = s_ready;
  assign m_axis_tdata_o  = out_data_q;
  assign m_axis_tvalid_o = out_valid_q;
  assign opcode_o        = opcode_q;
  assign length_o        = length_q;
  assign busy_o          = (state_q != StIdle);
  assign pkt_done_o      = done_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_alu_packet_parser.sv
// Self-checking bench for alu_packet_parser: directed frames plus randomized frames checked
// against a frame-level model (expected output byte queue and pulse counts).
module tb_alu_packet_parser;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  opcode;
  logic [15:0] length;
  logic        busy;
  logic        pkt_done;
  logic        err;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int exp_done = 0;
  int exp_err = 0;
  int rdy_pct = 100;
  logic [7:0] exp_q[$];
  logic [7:0] pl_q[$];

  alu_packet_parser #(
    .EchoOpcode   (8'hEC),
    .TimeoutCycles(50)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .s_axis_tdata_i (s_data),
    .s_axis_tvalid_i(s_valid),
    .s_axis_tready_o(s_ready),
    .m_axis_tdata_o (m_data),
    .m_axis_tvalid_o(m_valid),
    .m_axis_tready_i(m_ready),
    .opcode_o       (opcode),
    .length_o       (length),
    .busy_o         (busy),
    .pkt_done_o     (pkt_done),
    .err_o          (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sink-side readiness, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rdy_pct >= 100)    m_ready = 1'b1;
    else if (rdy_pct <= 0) m_ready = 1'b0;
    else                   m_ready = ($urandom_range(99) < rdy_pct);
  end

  // Output stream and pulse monitor.
  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      check_eq("out_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check_eq("out_data", 32'(m_data), 32'(exp_q.pop_front()));
    end
    if (pkt_done) done_cnt++;
    if (err) err_cnt++;
  end

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int  n;
    bit  acc;
    n = 0;
    acc = 1'b0;
    s_valid = 1'b1;
    s_data  = b;
    while (!acc) begin
      @(negedge clk);
      acc = s_ready;
      realign();
      n++;
      if (!acc && n > 5000) begin
        check_eq("send_accept", 32'(acc), 32'd1);
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic gap(input int pct);
    if ($urandom_range(99) < pct) repeat ($urandom_range(1, 3)) realign();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_frame(input logic [7:0] op, input logic [15:0] len, input bit lat_chk,
                           input int gap_pct);
    int         npay;
    logic [7:0] b;
    logic [7:0] hdr[4];
    npay   = (len > 16'd4) ? int'(len) - 4 : 0;
    hdr[0] = op;
    hdr[1] = 8'($urandom);
    hdr[2] = len[7:0];
    hdr[3] = len[15:8];
    exp_done++;
    if (op != 8'hEC) exp_err++;
    for (int i = 0; i < 4; i++) begin
      gap(gap_pct);
      send_byte(hdr[i]);
      if (lat_chk && i == 0) begin
        @(negedge clk);
        check_eq("err_pulse", 32'(err), 32'(op != 8'hEC));
        realign();
      end
      if (lat_chk && i == 3) begin
        @(negedge clk);
        check_eq("short_done", 32'(pkt_done), 32'(len <= 16'd4));
        realign();
      end
    end
    for (int i = 0; i < npay; i++) begin
      b = (pl_q.size() > 0) ? pl_q.pop_front() : 8'($urandom);
      if (op == 8'hEC) exp_q.push_back(b);
      gap(gap_pct);
      send_byte(b);
      if (lat_chk && op == 8'hEC) begin
        @(negedge clk);
        check_eq("lat_valid", 32'(m_valid), 32'd1);
        check_eq("lat_data", 32'(m_data), 32'(b));
        realign();
      end
    end
    pl_q.delete();
    wait_drain();
    repeat (3) @(negedge clk);
    check_eq("done_cnt", 32'(done_cnt), 32'(exp_done));
    check_eq("err_cnt", 32'(err_cnt), 32'(exp_err));
    check_eq("opcode", 32'(opcode), 32'(op));
    check_eq("length", 32'(length), 32'(len));
    check_eq("busy_end", 32'(busy), 32'd0);
    realign();
  endtask

  task automatic check_reset_vals();
    check_eq("rst_s_ready", 32'(s_ready), 32'd1);
    check_eq("rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("rst_m_data", 32'(m_data), 32'd0);
    check_eq("rst_opcode", 32'(opcode), 32'd0);
    check_eq("rst_length", 32'(length), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(pkt_done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] op;
    reset_i = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    m_ready = 1'b1;
    repeat (3) realign();
    @(negedge clk);
    check_reset_vals();
    realign();
    reset_i = 1'b0;
    realign();

    // Echo with one-cycle latency.
    pl_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(8'hEC, 16'd8, 1'b1, 0);

    // Unknown opcode: drained, error after opcode.
    pl_q = '{8'hAA, 8'hBB};
    run_frame(8'h5A, 16'd6, 1'b1, 0);

    // Backpressure: second payload byte must stall while the first is pending.
    rdy_pct = 0;
    realign();
    exp_done++;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h03);
    send_byte(8'hEC);
    send_byte(8'h00);
    send_byte(8'h07);
    send_byte(8'h00);
    send_byte(8'h01);
    s_valid = 1'b1;
    s_data  = 8'h02;
    repeat (20) @(negedge clk);
    check_eq("bp_s_ready", 32'(s_ready), 32'd0);
    check_eq("bp_m_valid", 32'(m_valid), 32'd1);
    check_eq("bp_m_data", 32'(m_data), 32'h01);
    rdy_pct = 100;
    realign();
    send_byte(8'h02);
    send_byte(8'h03);
    wait_drain();
    repeat (3) @(negedge clk);
    check_eq("bp_done_cnt", 32'(done_cnt), 32'(exp_done));
    realign();

    // Short length then minimal payload.
    run_frame(8'hEC, 16'd3, 1'b1, 0);
    pl_q = '{8'h99};
    run_frame(8'hEC, 16'd5, 1'b1, 0);
    run_frame(8'hEC, 16'd0, 1'b1, 0);
    run_frame(8'h33, 16'd4, 1'b1, 0);

    // Reset mid-frame with an output byte pending.
    rdy_pct = 0;
    realign();
    send_byte(8'hEC);
    send_byte(8'h00);
    send_byte(8'h08);
    send_byte(8'h00);
    send_byte(8'h11);
    reset_i = 1'b1;
    realign();
    @(negedge clk);
    check_reset_vals();
    realign();
    reset_i = 1'b0;
    rdy_pct = 100;
    realign();
    pl_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    run_frame(8'hEC, 16'd8, 1'b1, 0);

`ifdef PKT_PARSER_TIMEOUT_EN
    // Partial frame abandoned; timeout must return to idle with an error.
    exp_err++;
    send_byte(8'hEC);
    send_byte(8'h00);
    repeat (60) @(negedge clk);
    check_eq("tmo_err_cnt", 32'(err_cnt), 32'(exp_err));
    check_eq("tmo_busy", 32'(busy), 32'd0);
    realign();
    run_frame(8'hEC, 16'd6, 1'b1, 0);
`endif

    // Randomized frames with random sink backpressure and input gaps.
    for (int f = 0; f < 40; f++) begin
      case ($urandom_range(2))
        0:       rdy_pct = 100;
        1:       rdy_pct = 50;
        default: rdy_pct = 20;
      endcase
      op = ($urandom_range(99) < 60) ? 8'hEC : 8'($urandom);
      run_frame(op, 16'($urandom_range(0, 20)), 1'b0, 30);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
